// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO block: WIDTH pads with input synchronisers, push-pull/open-drain
// output control and sticky per-pin edge interrupts.
module wb_gpio_irq #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic [3:0]       i_wb_sel,
    input  logic             i_wb_we,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    input  logic [WIDTH-1:0] i_gpio,
    output logic [WIDTH-1:0] o_gpio,
    output logic [WIDTH-1:0] o_gpio_oe,
    output logic             o_irq
);

    localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] out_q, dir_q, od_q, ien_q, iedge_q, istat_q, prev_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [2:0]       settle_cnt;
    logic             settled, req, wr;
    logic [WIDTH-1:0] wm, wd, s, rise, fall, evt, clr;
    logic [31:0]      rdata;
    logic             unused_bits;

    // Upper data bits and byte lanes beyond WIDTH are intentionally ignored.
    assign unused_bits = ^{i_wb_dat, i_wb_sel};

    always_comb begin
        wm = '0;
        for (int b = 0; b < WIDTH; b++) wm[b] = i_wb_sel[b/8];
    end

    assign wd      = i_wb_dat[WIDTH-1:0] & wm;
    assign req     = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr      = req & i_wb_we;
    assign s       = sync_q[SYNC_STAGES-1];
    assign settled = (settle_cnt == SETTLE);
    assign rise    = s & ~prev_q;
    assign fall    = ~s & prev_q;
    assign evt     = settled ? ((iedge_q & fall) | (~iedge_q & rise)) : '0;
    assign clr     = (wr && i_wb_adr == 3'd6) ? wd : '0;

    always_comb begin
        rdata = '0;
        case (i_wb_adr)
            3'd0:    rdata[WIDTH-1:0] = s;
            3'd1:    rdata[WIDTH-1:0] = out_q;
            3'd2:    rdata[WIDTH-1:0] = dir_q;
            3'd3:    rdata[WIDTH-1:0] = od_q;
            3'd4:    rdata[WIDTH-1:0] = ien_q;
            3'd5:    rdata[WIDTH-1:0] = iedge_q;
            3'd6:    rdata[WIDTH-1:0] = istat_q;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q      <= '0;
            dir_q      <= '0;
            od_q       <= '0;
            ien_q      <= '0;
            iedge_q    <= '0;
            istat_q    <= '0;
            prev_q     <= '0;
            settle_cnt <= '0;
            o_wb_ack   <= 1'b0;
            o_wb_rdt   <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= i_gpio;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q   <= s;
            if (!settled) settle_cnt <= settle_cnt + 3'd1;
            o_wb_ack <= req;
            o_wb_rdt <= req ? rdata : '0;
            // Event set takes priority over a same-cycle W1C.
            istat_q  <= (istat_q & ~clr) | evt;
            if (wr) begin
                case (i_wb_adr)
                    3'd1:    out_q   <= (out_q   & ~wm) | wd;
                    3'd2:    dir_q   <= (dir_q   & ~wm) | wd;
                    3'd3:    od_q    <= (od_q    & ~wm) | wd;
                    3'd4:    ien_q   <= (ien_q   & ~wm) | wd;
                    3'd5:    iedge_q <= (iedge_q & ~wm) | wd;
                    default: ;
                endcase
            end
        end
    end

    assign o_gpio    = out_q & ~od_q;
    assign o_gpio_oe = dir_q & ~(od_q & out_q);
    assign o_irq     = |(istat_q & ien_q);

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed bench for wb_gpio_irq (WIDTH=8, SYNC_STAGES=2): register vector
// table plus hand sequences for interrupt timing, settle masking and reset.
module tb_wb_gpio_irq;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [31:0] rdt;
    logic        ack;
    logic [7:0]  gpio_in, gpio, oe;
    logic        irq;
    int          total = 0;
    int          bad = 0;

    wb_gpio_irq #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel), .i_wb_we(we),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_rdt(rdt), .o_wb_ack(ack),
        .i_gpio(gpio_in), .o_gpio(gpio), .o_gpio_oe(oe), .o_irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_rd;
        logic [7:0]  exp_gpio;
        logic [7:0]  exp_oe;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the bus idle; ack must follow on the next edge.
    task automatic bus(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, output logic [31:0] r);
        adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("ack_rise", {31'd0, ack}, 32'd1);
        r = rdt;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("ack_fall", {31'd0, ack}, 32'd0);
        chk("rdt_idle", rdt, 32'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        bus(a, d, s, 1'b1, r);
    endtask

    task automatic rdchk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(a, 32'hDEAD_BEEF, 4'hF, 1'b0, r);
        chk(nm, r, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{3'd1, 32'h0000_00A5, 4'hF, 32'hA5, 8'hA5, 8'h00};
        vecs[1]  = '{3'd2, 32'h0000_000F, 4'hF, 32'h0F, 8'hA5, 8'h0F};
        vecs[2]  = '{3'd1, 32'hFFFF_FF5A, 4'h1, 32'h5A, 8'h5A, 8'h0F};
        vecs[3]  = '{3'd1, 32'h0000_00FF, 4'h0, 32'h5A, 8'h5A, 8'h0F};
        vecs[4]  = '{3'd7, 32'hFFFF_FFFF, 4'hF, 32'h00, 8'h5A, 8'h0F};
        vecs[5]  = '{3'd0, 32'h0000_0000, 4'hF, 32'h7F, 8'h5A, 8'h0F};
        vecs[6]  = '{3'd2, 32'h0000_0001, 4'hF, 32'h01, 8'h5A, 8'h01};
        vecs[7]  = '{3'd3, 32'h0000_0001, 4'hF, 32'h01, 8'h5A, 8'h01};
        vecs[8]  = '{3'd1, 32'h0000_0000, 4'hF, 32'h00, 8'h00, 8'h01};
        vecs[9]  = '{3'd1, 32'h0000_0001, 4'hF, 32'h01, 8'h00, 8'h00};
        vecs[10] = '{3'd1, 32'h0000_00FF, 4'hF, 32'hFF, 8'hFE, 8'h00};
        vecs[11] = '{3'd2, 32'h0000_00FF, 4'hF, 32'hFF, 8'hFE, 8'hFE};
        vecs[12] = '{3'd3, 32'h0000_0000, 4'hF, 32'h00, 8'hFF, 8'hFF};
        vecs[13] = '{3'd4, 32'h1234_5603, 4'hF, 32'h03, 8'hFF, 8'hFF};
        vecs[14] = '{3'd4, 32'h0000_0000, 4'hF, 32'h00, 8'hFF, 8'hFF};
        vecs[15] = '{3'd5, 32'h0000_FF00, 4'h2, 32'h00, 8'hFF, 8'hFF};

        rst = 1'b1; adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        gpio_in = 8'hFF;
        idle(3);
        chk("rst_ack",  {31'd0, ack}, 32'd0);
        chk("rst_rdt",  rdt, 32'd0);
        chk("rst_gpio", {24'd0, gpio}, 32'd0);
        chk("rst_oe",   {24'd0, oe}, 32'd0);
        chk("rst_irq",  {31'd0, irq}, 32'd0);
        rst = 1'b0;

        // Pads high through reset release must not raise events.
        idle(6);
        rdchk("settle_istat", 3'd6, 32'h00);
        rdchk("in_ff", 3'd0, 32'hFF);
        wr(3'd5, 32'h80, 4'hF);
        gpio_in = 8'h7F;
        idle(6);
        rdchk("fall_b7_istat", 3'd6, 32'h80);
        chk("fall_b7_noirq", {31'd0, irq}, 32'd0);
        wr(3'd6, 32'h80, 4'hF);
        rdchk("fall_b7_clr", 3'd6, 32'h00);
        wr(3'd5, 32'h00, 4'hF);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] r;
            wr(vecs[i].a, vecs[i].d, vecs[i].s);
            bus(vecs[i].a, 32'h0, 4'hF, 1'b0, r);
            chk($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
            chk($sformatf("vec%0d_gpio", i), {24'd0, gpio}, {24'd0, vecs[i].exp_gpio});
            chk($sformatf("vec%0d_oe", i), {24'd0, oe}, {24'd0, vecs[i].exp_oe});
        end

        // Rising-edge interrupt latency on bit 2.
        gpio_in = 8'h00;
        idle(6);
        rdchk("falls_ignored", 3'd6, 32'h00);
        wr(3'd4, 32'h04, 4'hF);
        gpio_in = 8'h04;
        idle(1); chk("irq_n1", {31'd0, irq}, 32'd0);
        idle(1); chk("irq_n2", {31'd0, irq}, 32'd0);
        idle(1); chk("irq_n3", {31'd0, irq}, 32'd1);
        rdchk("istat_b2", 3'd6, 32'h04);
        wr(3'd6, 32'h04, 4'hF);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        rdchk("istat_clr", 3'd6, 32'h00);
        gpio_in = 8'h00;
        idle(6);
        chk("fall_noirq", {31'd0, irq}, 32'd0);
        rdchk("fall_noevt", 3'd6, 32'h00);

        // W1C only clears with the covering byte lane enabled.
        gpio_in = 8'h04;
        idle(6);
        wr(3'd6, 32'h04, 4'h0);
        rdchk("w1c_sel0", 3'd6, 32'h04);
        wr(3'd6, 32'h04, 4'h1);
        rdchk("w1c_sel1", 3'd6, 32'h00);
        gpio_in = 8'h00;
        idle(6);

        // Event on bit 1 landing on the same edge as its W1C.
        gpio_in = 8'h02;
        idle(6);
        rdchk("b1_set", 3'd6, 32'h02);
        gpio_in = 8'h00;
        idle(6);
        gpio_in = 8'h02;
        idle(2);
        wr(3'd6, 32'h02, 4'hF);
        rdchk("set_wins", 3'd6, 32'h02);
        wr(3'd4, 32'h02, 4'hF);
        chk("ien_irq", {31'd0, irq}, 32'd1);

        // Reset while a write strobe is held aborts it.
        adr = 3'd2; dat = 32'h0; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        rst = 1'b1;
        idle(1);
        chk("abort_ack",  {31'd0, ack}, 32'd0);
        chk("abort_oe",   {24'd0, oe}, 32'd0);
        chk("abort_gpio", {24'd0, gpio}, 32'd0);
        chk("abort_irq",  {31'd0, irq}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        idle(1);
        rst = 1'b0;
        idle(6);
        rdchk("post_rst_dir", 3'd2, 32'h00);
        rdchk("post_rst_istat", 3'd6, 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
